bus_tx_framer: RTL

//  Upstream framer for the shared-bus interface block. Accepts one transaction request
//  (src, dest, op, length) plus payload bytes into a local FIFO.

---
 rtl/bus_tx_framer_pkg.sv | 35 +++
 rtl/bus_tx_framer_if.sv | 43 ++++
 rtl/bus_tx_framer_fifo.sv | 55 +++++
 rtl/bus_tx_framer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bus_tx_framer_pkg.sv
// rtl/bus_tx_framer_pkg.sv - shared constants, header layout and FSM encoding for the bus tx framer
package bus_tx_framer_pkg;

    // Header byte layout: {op, src, dest, 2'b00}
    localparam int HDR_OP_HI  = 7;
    localparam int HDR_OP_LO  = 6;
    localparam int HDR_SRC_HI = 5;
    localparam int HDR_SRC_LO = 4;
    localparam int HDR_DST_HI = 3;
    localparam int HDR_DST_LO = 2;

    // Module IDs on the shared bus
    localparam logic [1:0] CTRL_ID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    // Pack request fields into the header byte; the two low bits are reserved zeros
    function automatic logic [7:0] make_header(input logic [1:0] op,
                                               input logic [1:0] src,
                                               input logic [1:0] dst);
        logic [7:0] h;
        h = 8'h00;
        h[HDR_OP_HI:HDR_OP_LO]   = op;
        h[HDR_SRC_HI:HDR_SRC_LO] = src;
        h[HDR_DST_HI:HDR_DST_LO] = dst;
        return h;
    endfunction

endpackage

// File: rtl/bus_tx_framer_if.sv
// rtl/bus_tx_framer_if.sv - request, payload-write, send and status signals of the framer
interface bus_tx_framer_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_src;
    logic [1:0] req_dest;
    logic [1:0] req_op;
    logic [7:0] req_len;

    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;

    logic       send_valid;
    logic [7:0] send_data;
    logic       send_ready;

    logic       ack;
    logic       err;
    logic       busy;

    // Host side: issues requests and payload, drains the send stream
    modport master (
        output req_valid, req_src, req_dest, req_op, req_len,
        output wr_valid, wr_data,
        output send_ready,
        input  req_ready, wr_ready,
        input  send_valid, send_data,
        input  ack, err, busy
    );

    // Framer side
    modport slave (
        input  req_valid, req_src, req_dest, req_op, req_len,
        input  wr_valid, wr_data,
        input  send_ready,
        output req_ready, wr_ready,
        output send_valid, send_data,
        output ack, err, busy
    );

endinterface

// File: rtl/bus_tx_framer_fifo.sv
// rtl/bus_tx_framer_fifo.sv - synchronous payload FIFO with flush and registered head
module bus_tx_framer_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW-1:0]    w_wr_idx;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;
    // A byte written during a flush survives as the first entry of the cleared FIFO
    assign w_wr_idx  = i_flush ? '0 : r_wr_ptr[AW-1:0];
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update: flush clears both, otherwise independent push/pop advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= w_push_ok ? (AW+1)'(1) : '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[w_wr_idx] <= i_data;
    end

endmodule

// File: rtl/bus_tx_framer.sv
// rtl/bus_tx_framer.sv - framer emitting header plus payload bytes with ack and stall watchdog
module bus_tx_framer
    import bus_tx_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_tx_framer_if.slave bus
);

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [7:0]     r_hdr;
    logic [7:0]     r_remaining;
    logic [WDW-1:0] r_wdog;

    logic       w_accept;
    logic       w_wdog_expire;
    logic       w_send_valid;
    logic [7:0] w_send_data;
    logic       w_xfer;
    logic       w_pop;
    logic       w_flush;
    logic       w_ack;
    logic       w_err;
    logic       w_req_ready;

    logic       w_fifo_push;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_head;

    assign w_accept      = (r_state == ST_IDLE) && bus.req_valid;
    // This stall would be the TIMEOUT-th in a row, so leave for ABORT now
    assign w_wdog_expire = (r_wdog == WD_LAST);
    assign w_fifo_push   = bus.wr_valid && !w_fifo_full;

    bus_tx_framer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fifo_push),
        .i_data  (bus.wr_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and per-state outputs
    always_comb begin
        w_state_next = r_state;
        w_send_valid = 1'b0;
        w_send_data  = 8'h00;
        w_xfer       = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_ack        = 1'b0;
        w_err        = 1'b0;
        w_req_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_next = ST_HDR;
            end
            ST_HDR: begin
                w_send_valid = 1'b1;
                w_send_data  = r_hdr;
                w_xfer       = bus.send_ready;
                if (w_xfer)             w_state_next = (r_remaining != 8'd0) ? ST_PAYLOAD : ST_DONE;
                else if (w_wdog_expire) w_state_next = ST_ABORT;
            end
            ST_PAYLOAD: begin
                w_send_valid = !w_fifo_empty;
                w_send_data  = w_fifo_empty ? 8'h00 : w_fifo_head;
                w_xfer       = w_send_valid && bus.send_ready;
                w_pop        = w_xfer;
                if (w_xfer) begin
                    if (r_remaining == 8'd1) w_state_next = ST_DONE;
                end else if (w_wdog_expire) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_DONE: begin
                w_ack        = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_ABORT: begin
                w_ack        = 1'b1;
                w_err        = 1'b1;
                w_flush      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Header/length latch on accept, remaining-count and watchdog tracking while sending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr       <= 8'h00;
            r_remaining <= 8'h00;
            r_wdog      <= '0;
        end else if (w_accept) begin
            r_hdr       <= make_header(bus.req_op, bus.req_src, bus.req_dest);
            r_remaining <= bus.req_len;
            r_wdog      <= '0;
        end else if (r_state == ST_HDR || r_state == ST_PAYLOAD) begin
            if (w_xfer) begin
                r_wdog <= '0;
                if (r_state == ST_PAYLOAD) r_remaining <= r_remaining - 8'd1;
            end else if (!w_wdog_expire) begin
                r_wdog <= r_wdog + WDW'(1);
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.wr_ready   = !w_fifo_full;
    assign bus.send_valid = w_send_valid;
    assign bus.send_data  = w_send_data;
    assign bus.ack        = w_ack;
    assign bus.err        = w_err;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
